// File: rtl/riscv_int_controller_pkg.sv
// Shared constants for the exception/interrupt controller: cause codes, IF PC mux
// selections, debug-settings bit positions and the handshake FSM state type.
package riscv_int_controller_pkg;

  localparam int DBG_SETS_W     = 6;
  localparam int DBG_SETS_IRQ   = 5;
  localparam int DBG_SETS_ECALL = 4;
  localparam int DBG_SETS_EILL  = 3;
  localparam int DBG_SETS_ELSU  = 2;
  localparam int DBG_SETS_EBRK  = 1;
  localparam int DBG_SETS_SSTE  = 0;

  // Load and store faults share one handler entry point.
  localparam logic [1:0] EXC_PC_ILLINSN = 2'b00;
  localparam logic [1:0] EXC_PC_ECALL   = 2'b01;
  localparam logic [1:0] EXC_PC_LOAD    = 2'b10;
  localparam logic [1:0] EXC_PC_STORE   = 2'b10;
  localparam logic [1:0] EXC_PC_IRQ     = 2'b11;

  localparam logic [5:0] EXC_CAUSE_ILLEGAL_INSN = 6'b0_00010;
  localparam logic [5:0] EXC_CAUSE_BREAKPOINT   = 6'b0_00011;
  localparam logic [5:0] EXC_CAUSE_LOAD_FAULT   = 6'b0_00101;
  localparam logic [5:0] EXC_CAUSE_STORE_FAULT  = 6'b0_00111;
  localparam logic [5:0] EXC_CAUSE_ECALL_MMODE  = 6'b0_01011;

  typedef enum logic {
    IDLE,
    WAIT_CTRL
  } exc_ctrl_state_e;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Combinational priority encoder: reports whether any line is set and the lowest set index.
module riscv_irq_prio_enc #(
  parameter int N_IRQ = 32
) (
  input  logic [N_IRQ-1:0] irq_i,
  output logic             valid_o,
  output logic [4:0]       idx_o
);

  always_comb begin
    valid_o = |irq_i;
    idx_o   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (irq_i[i]) idx_o = 5'(i);
    end
  end

endmodule

// File: rtl/riscv_int_controller.sv
// Exception/interrupt arbiter with a req/ack handshake towards the core controller.
// state     | meaning
// IDLE      | outputs follow live arbitration; a request not acked this cycle is snapshotted
// WAIT_CTRL | request held from the snapshot until the controller acks
module riscv_int_controller
  import riscv_int_controller_pkg::*;
#(
  parameter int               N_IRQ    = 32,
  parameter logic [N_IRQ-1:0] IRQ_EDGE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_o,
  input  logic                  ack_i,
  output logic                  trap_o,
  output logic [1:0]            pc_mux_o,
  output logic [4:0]            vec_pc_mux_o,
  input  logic [N_IRQ-1:0]      irq_i,
  input  logic [N_IRQ-1:0]      irq_mask_i,
  input  logic                  irq_enable_i,
  output logic                  irq_ack_o,
  output logic [4:0]            irq_id_o,
  input  logic                  ebrk_insn_i,
  input  logic                  illegal_insn_i,
  input  logic                  ecall_insn_i,
  input  logic                  lsu_load_err_i,
  input  logic                  lsu_store_err_i,
  output logic [5:0]            cause_o,
  output logic                  save_cause_o,
  input  logic [DBG_SETS_W-1:0] dbg_settings_i
);

  exc_ctrl_state_e  state_q, state_d;
  logic [N_IRQ-1:0] irq_q, irq_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [5:0]       cause_q, cause_d;
  logic [1:0]       pc_mux_q, pc_mux_d;

  logic [N_IRQ-1:0] active;
  logic             irq_valid;
  logic [4:0]       irq_idx;
  logic             exc_any;
  logic             req_int;
  logic [5:0]       cause_arb;
  logic [1:0]       pc_mux_arb;

  assign active = ((IRQ_EDGE & pending_q) | (~IRQ_EDGE & irq_i)) & irq_mask_i
                  & {N_IRQ{irq_enable_i}};

  riscv_irq_prio_enc #(.N_IRQ(N_IRQ)) u_prio_enc (
    .irq_i   (active),
    .valid_o (irq_valid),
    .idx_o   (irq_idx)
  );

  assign exc_any = lsu_store_err_i | lsu_load_err_i | illegal_insn_i | ecall_insn_i;
  assign req_int = exc_any | irq_valid;

  always_comb begin
    cause_arb  = '0;
    pc_mux_arb = EXC_PC_ILLINSN;
    if (lsu_store_err_i) begin
      cause_arb  = EXC_CAUSE_STORE_FAULT;
      pc_mux_arb = EXC_PC_STORE;
    end else if (lsu_load_err_i) begin
      cause_arb  = EXC_CAUSE_LOAD_FAULT;
      pc_mux_arb = EXC_PC_LOAD;
    end else if (illegal_insn_i) begin
      cause_arb  = EXC_CAUSE_ILLEGAL_INSN;
      pc_mux_arb = EXC_PC_ILLINSN;
    end else if (ecall_insn_i) begin
      cause_arb  = EXC_CAUSE_ECALL_MMODE;
      pc_mux_arb = EXC_PC_ECALL;
    end else if (irq_valid) begin
      cause_arb  = {1'b1, irq_idx};
      pc_mux_arb = EXC_PC_IRQ;
    end else if (ebrk_insn_i) begin
      // Breakpoint never requests; the cause is only presented for the CSR.
      cause_arb  = EXC_CAUSE_BREAKPOINT;
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    pc_mux_d = pc_mux_q;
    req_o    = 1'b0;
    cause_o  = cause_arb;
    pc_mux_o = pc_mux_arb;
    case (state_q)
      IDLE: begin
        req_o = req_int;
        if (req_int) begin
          cause_d  = cause_arb;
          pc_mux_d = pc_mux_arb;
          if (!ack_i) state_d = WAIT_CTRL;
        end
      end
      WAIT_CTRL: begin
        req_o    = 1'b1;
        cause_o  = cause_q;
        pc_mux_o = pc_mux_q;
        if (ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign save_cause_o = req_o & ack_i;
  assign irq_ack_o    = save_cause_o & cause_o[5];
  assign irq_id_o     = cause_o[4:0];
  assign vec_pc_mux_o = cause_o[4:0];

  // A new edge on the line being acknowledged wins over the clear.
  always_comb begin
    irq_d     = irq_i;
    pending_d = pending_q;
    for (int i = 0; i < N_IRQ; i++) begin
      if (irq_ack_o && irq_id_o == 5'(i)) pending_d[i] = 1'b0;
    end
    pending_d = pending_d | (irq_i & ~irq_q & IRQ_EDGE);
  end

  assign trap_o = dbg_settings_i[DBG_SETS_SSTE]
                | ((|active) & dbg_settings_i[DBG_SETS_IRQ])
                | (ecall_insn_i & dbg_settings_i[DBG_SETS_ECALL])
                | (illegal_insn_i & dbg_settings_i[DBG_SETS_EILL])
                | ((lsu_load_err_i | lsu_store_err_i) & dbg_settings_i[DBG_SETS_ELSU])
                | (ebrk_insn_i & dbg_settings_i[DBG_SETS_EBRK]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      cause_q   <= '0;
      pc_mux_q  <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      pending_q <= pending_d;
      cause_q   <= cause_d;
      pc_mux_q  <= pc_mux_d;
    end
  end

endmodule

// File: tb/tb_riscv_int_controller.sv
// Directed bench for riscv_int_controller; lines 1 and 7 are edge-triggered, the rest level.
module tb_riscv_int_controller;

  localparam int          N_IRQ    = 32;
  localparam logic [31:0] IRQ_EDGE = 32'h0000_0082;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_o, ack_i, trap_o;
  logic [1:0]  pc_mux_o;
  logic [4:0]  vec_pc_mux_o;
  logic [31:0] irq_i, irq_mask_i;
  logic        irq_enable_i;
  logic        irq_ack_o;
  logic [4:0]  irq_id_o;
  logic        ebrk_insn_i, illegal_insn_i, ecall_insn_i, lsu_load_err_i, lsu_store_err_i;
  logic [5:0]  cause_o;
  logic        save_cause_o;
  logic [5:0]  dbg_settings_i;

  int total = 0;
  int bad   = 0;

  riscv_int_controller #(.N_IRQ(N_IRQ), .IRQ_EDGE(IRQ_EDGE)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_o           (req_o),
    .ack_i           (ack_i),
    .trap_o          (trap_o),
    .pc_mux_o        (pc_mux_o),
    .vec_pc_mux_o    (vec_pc_mux_o),
    .irq_i           (irq_i),
    .irq_mask_i      (irq_mask_i),
    .irq_enable_i    (irq_enable_i),
    .irq_ack_o       (irq_ack_o),
    .irq_id_o        (irq_id_o),
    .ebrk_insn_i     (ebrk_insn_i),
    .illegal_insn_i  (illegal_insn_i),
    .ecall_insn_i    (ecall_insn_i),
    .lsu_load_err_i  (lsu_load_err_i),
    .lsu_store_err_i (lsu_store_err_i),
    .cause_o         (cause_o),
    .save_cause_o    (save_cause_o),
    .dbg_settings_i  (dbg_settings_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ack_i = 0; irq_i = '0; ebrk_insn_i = 0; illegal_insn_i = 0; ecall_insn_i = 0;
    lsu_load_err_i = 0; lsu_store_err_i = 0; dbg_settings_i = '0;
  endtask

  initial begin
    clear_inputs();
    irq_mask_i = '1; irq_enable_i = 1; rst = 1;
    tick(); tick();
    chk("rst_req", 32'(req_o), 32'h0);
    chk("rst_save", 32'(save_cause_o), 32'h0);
    chk("rst_irqack", 32'(irq_ack_o), 32'h0);
    rst = 0;
    tick();

    // level line 5 taken with ack in the same cycle
    irq_i = 32'h20; ack_i = 1; #1;
    chk("t1_req", 32'(req_o), 32'h1);
    chk("t1_cause", 32'(cause_o), 32'h25);
    chk("t1_pcmux", 32'(pc_mux_o), 32'h3);
    chk("t1_save", 32'(save_cause_o), 32'h1);
    chk("t1_irqack", 32'(irq_ack_o), 32'h1);
    chk("t1_irqid", 32'(irq_id_o), 32'h5);
    chk("t1_vec", 32'(vec_pc_mux_o), 32'h5);
    tick();
    clear_inputs(); #1;
    chk("t1_idle_req", 32'(req_o), 32'h0);
    tick();

    // lines 3 and 9, delayed ack; line 3 drops while waiting
    irq_i = 32'h208; #1;
    chk("t2_req0", 32'(req_o), 32'h1);
    chk("t2_cause0", 32'(cause_o), 32'h23);
    chk("t2_save0", 32'(save_cause_o), 32'h0);
    tick();
    irq_i = 32'h200; #1;
    chk("t2_cause1", 32'(cause_o), 32'h23);
    chk("t2_req1", 32'(req_o), 32'h1);
    tick(); #1;
    chk("t2_cause2", 32'(cause_o), 32'h23);
    ack_i = 1; #1;
    chk("t2_cause3", 32'(cause_o), 32'h23);
    chk("t2_irqid3", 32'(irq_id_o), 32'h3);
    chk("t2_irqack3", 32'(irq_ack_o), 32'h1);
    tick();
    ack_i = 0; #1;
    chk("t2_req4", 32'(req_o), 32'h1);
    chk("t2_cause4", 32'(cause_o), 32'h29);
    ack_i = 1;
    tick();
    clear_inputs();
    tick();

    // masked edge on line 7 latches pending
    irq_mask_i = ~32'h80; irq_i = 32'h80; #1;
    chk("t3_req0", 32'(req_o), 32'h0);
    tick();
    irq_i = '0; #1;
    chk("t3_req1", 32'(req_o), 32'h0);
    tick();
    irq_mask_i = '1; #1;
    chk("t3_req2", 32'(req_o), 32'h1);
    chk("t3_cause2", 32'(cause_o), 32'h27);
    ack_i = 1; #1;
    chk("t3_irqack", 32'(irq_ack_o), 32'h1);
    tick();
    ack_i = 0; #1;
    chk("t3_req3", 32'(req_o), 32'h0);
    tick();

    // store error beats illegal and irq
    illegal_insn_i = 1; lsu_store_err_i = 1; irq_i = 32'h1; #1;
    chk("t4_cause", 32'(cause_o), 32'h07);
    chk("t4_pcmux", 32'(pc_mux_o), 32'h2);
    ack_i = 1; #1;
    chk("t4_irqack", 32'(irq_ack_o), 32'h0);
    tick();
    clear_inputs();
    ebrk_insn_i = 1; #1;
    chk("ebrk_cause", 32'(cause_o), 32'h03);
    chk("ebrk_req", 32'(req_o), 32'h0);
    chk("ebrk_trap_off", 32'(trap_o), 32'h0);
    dbg_settings_i = 6'b000010; #1;
    chk("ebrk_trap_on", 32'(trap_o), 32'h1);
    clear_inputs();
    dbg_settings_i = 6'b000001; #1;
    chk("sste_trap", 32'(trap_o), 32'h1);
    clear_inputs();
    ecall_insn_i = 1; #1;
    chk("ecall_cause", 32'(cause_o), 32'h0b);
    chk("ecall_pcmux", 32'(pc_mux_o), 32'h1);
    ack_i = 1;
    tick();
    clear_inputs();
    tick();

    // snapshot irq 2 held while ecall and load_err arrive
    irq_i = 32'h4; #1;
    chk("t5_cause0", 32'(cause_o), 32'h22);
    tick();
    ecall_insn_i = 1; #1;
    chk("t5_cause1", 32'(cause_o), 32'h22);
    tick();
    lsu_load_err_i = 1; #1;
    chk("t5_cause2", 32'(cause_o), 32'h22);
    chk("t5_pcmux2", 32'(pc_mux_o), 32'h3);
    ack_i = 1; #1;
    chk("t5_irqack", 32'(irq_ack_o), 32'h1);
    tick();
    ack_i = 0; #1;
    chk("t5_req3", 32'(req_o), 32'h1);
    chk("t5_cause3", 32'(cause_o), 32'h05);
    chk("t5_pcmux3", 32'(pc_mux_o), 32'h2);
    ack_i = 1;
    tick();
    clear_inputs();
    tick();

    // reset mid-handshake drops pending edge on line 1
    irq_i = 32'h2; #1;
    chk("t6_req0", 32'(req_o), 32'h0);
    tick();
    irq_i = '0; #1;
    chk("t6_req1", 32'(req_o), 32'h1);
    chk("t6_cause1", 32'(cause_o), 32'h21);
    tick(); #1;
    chk("t6_wait_req", 32'(req_o), 32'h1);
    rst = 1;
    tick();
    rst = 0; #1;
    chk("t6_req_after_rst", 32'(req_o), 32'h0);
    tick(); #1;
    chk("t6_pending_lost", 32'(req_o), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
